// File: rtl/mips_cycle_pc_unit_if.sv
// Bundle between the front-panel/control side and the cycle/PC unit.
// The master drives run control and PC sources; the slave returns timer and PC state.
interface mips_cycle_pc_unit_if #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned NUM_CYCLES = 5
);
    logic                  key_ok;
    logic                  halt;
    logic                  load_pc;
    logic                  offset;
    logic [WORD_SIZE-1:0]  data_in;
    logic [NUM_CYCLES-1:0] timer;
    logic [WORD_SIZE-1:0]  pc_counter;
    logic [WORD_SIZE-1:0]  pc_next;
    logic                  cycle_last;
    logic                  pc_wrap;
    logic                  running;

    modport master (
        output key_ok, halt, load_pc, offset, data_in,
        input  timer, pc_counter, pc_next, cycle_last, pc_wrap, running
    );

    modport slave (
        input  key_ok, halt, load_pc, offset, data_in,
        output timer, pc_counter, pc_next, cycle_last, pc_wrap, running
    );
endinterface

// File: rtl/mips_cycle_pc_unit.sv
// One-hot multi-cycle timer and program counter for the mipscpu core.
// Define CYCLE_STEP_EN to advance one cycle per rising edge of key_ok instead of per clock.
module mips_cycle_pc_unit #(
    parameter int unsigned         WORD_SIZE  = 16,
    parameter int unsigned         NUM_CYCLES = 5,
    parameter int unsigned         PC_STEP    = 1,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input logic               clk_i,
    input logic               rst_ni,
    mips_cycle_pc_unit_if.slave bus
);

    localparam logic [NUM_CYCLES-1:0] Cycle0    = {{(NUM_CYCLES-1){1'b0}}, 1'b1};
    localparam logic [NUM_CYCLES-1:0] CycleLast = {1'b1, {(NUM_CYCLES-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e                state_q, state_d;
    logic [NUM_CYCLES-1:0] timer_q, timer_d;
    logic [WORD_SIZE-1:0]  pc_q, pc_d;
    logic                  wrap_q, wrap_d;

    logic                  advance;
    logic                  timer_onehot;
    logic [WORD_SIZE:0]    inc_sum;
    logic [WORD_SIZE-1:0]  off_sum;
    logic                  off_ovf;
    logic [WORD_SIZE-1:0]  pc_next;
    logic                  wrap_upd;

`ifdef CYCLE_STEP_EN
    logic key_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q <= 1'b0;
        end else begin
            key_q <= bus.key_ok;
        end
    end

    assign advance = bus.key_ok & ~key_q;
`else
    assign advance = bus.key_ok;
`endif

    assign timer_onehot = (timer_q != '0) && ((timer_q & (timer_q - Cycle0)) == '0);

    assign inc_sum = {1'b0, pc_q} + (WORD_SIZE+1)'(PC_STEP);
    assign off_sum = pc_q + bus.data_in;
    // Signed overflow: operands agree in sign but the result does not.
    assign off_ovf = (pc_q[WORD_SIZE-1] == bus.data_in[WORD_SIZE-1]) &&
                     (off_sum[WORD_SIZE-1] != pc_q[WORD_SIZE-1]);

    always_comb begin
        pc_next  = inc_sum[WORD_SIZE-1:0];
        wrap_upd = inc_sum[WORD_SIZE];
        if (bus.load_pc) begin
            pc_next  = bus.data_in;
            wrap_upd = 1'b0;
        end else if (bus.offset) begin
            pc_next  = off_sum;
            wrap_upd = off_ovf;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pc_d    = pc_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (advance) begin
                    state_d = StRun;
                    timer_d = Cycle0;
                end
            end
            StRun: begin
                if (advance) begin
                    if (!timer_onehot) begin
                        timer_d = Cycle0;
                    end else if (timer_q == CycleLast) begin
                        pc_d   = pc_next;
                        wrap_d = wrap_upd;
                        if (bus.halt) begin
                            state_d = StHalt;
                            timer_d = '0;
                        end else begin
                            timer_d = Cycle0;
                        end
                    end else begin
                        timer_d = timer_q << 1;
                    end
                end
            end
            StHalt: begin
                timer_d = '0;
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            timer_q <= '0;
            pc_q    <= RESET_PC;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.timer      = timer_q;
    assign bus.pc_counter = pc_q;
    assign bus.pc_next    = pc_next;
    assign bus.running    = (state_q == StRun);
    assign bus.cycle_last = timer_q[NUM_CYCLES-1] & (state_q == StRun);
    assign bus.pc_wrap    = wrap_q;

endmodule

// File: tb/tb_mips_cycle_pc_unit.sv
// Directed bench for mips_cycle_pc_unit: a reference model pushes the expected post-edge state
// into a queue as each stimulus step is driven; it is popped and checked after the edge.
module tb_mips_cycle_pc_unit;

    localparam int W = 16;
    localparam int N = 5;
    localparam logic [N-1:0] LastT = 5'b10000;

    typedef struct {
        logic [N-1:0] timer;
        logic [W-1:0] pc;
        logic         wrap;
        logic         run;
        logic         last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_cycle_pc_unit_if #(.WORD_SIZE(W), .NUM_CYCLES(N)) bus ();

    mips_cycle_pc_unit #(
        .WORD_SIZE (W),
        .NUM_CYCLES(N),
        .PC_STEP   (1),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_err    = 0;

    // Reference model state: 0 idle, 1 run, 2 halt.
    int           m_state;
    logic [N-1:0] m_timer;
    logic [W-1:0] m_pc;
    logic         m_wrap;
    logic         m_key_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        bus.key_ok  = 1'b0;
        bus.halt    = 1'b0;
        bus.load_pc = 1'b0;
        bus.offset  = 1'b0;
        bus.data_in = '0;
        rst_n = 1'b0;
        #1;
        m_state = 0; m_timer = '0; m_pc = '0; m_wrap = 1'b0; m_key_prev = 1'b0;
        sb_q.delete();
        chk("rst_timer", bus.timer, 0);
        chk("rst_pc", bus.pc_counter, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_wrap", bus.pc_wrap, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic key, input logic h, input logic ld, input logic of,
                        input logic [W-1:0] d);
        logic [W-1:0] exp_next;
        logic         exp_wrap;
        logic         adv;
        int           a, b, s, u;
        exp_t         e;
        bus.key_ok  = key;
        bus.halt    = h;
        bus.load_pc = ld;
        bus.offset  = of;
        bus.data_in = d;
        #1;
        u = int'(m_pc) + 1;
        a = int'($signed(m_pc));
        b = int'($signed(d));
        s = a + b;
        if (ld) begin
            exp_next = d;
            exp_wrap = 1'b0;
        end else if (of) begin
            exp_next = s[W-1:0];
            exp_wrap = (s > 32767) || (s < -32768);
        end else begin
            exp_next = u[W-1:0];
            exp_wrap = (u > 65535);
        end
        chk("pc_next", bus.pc_next, exp_next);
`ifdef CYCLE_STEP_EN
        adv = key && !m_key_prev;
`else
        adv = key;
`endif
        m_key_prev = key;
        m_wrap = 1'b0;
        if (m_state == 0 && adv) begin
            m_state = 1;
            m_timer = 5'b00001;
        end else if (m_state == 1 && adv) begin
            if (m_timer == LastT) begin
                m_pc   = exp_next;
                m_wrap = exp_wrap;
                if (h) begin
                    m_state = 2;
                    m_timer = '0;
                end else begin
                    m_timer = 5'b00001;
                end
            end else begin
                m_timer = m_timer << 1;
            end
        end
        e.timer = m_timer;
        e.pc    = m_pc;
        e.wrap  = m_wrap;
        e.run   = (m_state == 1);
        e.last  = (m_state == 1) && m_timer[N-1];
        sb_q.push_back(e);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        chk("timer", bus.timer, e.timer);
        chk("pc", bus.pc_counter, e.pc);
        chk("pc_wrap", bus.pc_wrap, e.wrap);
        chk("running", bus.running, e.run);
        chk("cycle_last", bus.cycle_last, e.last);
    endtask

    // One guaranteed advance in either build.
    task automatic adv_step(input logic h, input logic ld, input logic of, input logic [W-1:0] d);
`ifdef CYCLE_STEP_EN
        step(1'b0, h, ld, of, d);
`endif
        step(1'b1, h, ld, of, d);
    endtask

    task automatic run_to_last();
        for (int i = 0; i < 2 * N + 2; i++) begin
            if (m_state == 1 && m_timer == LastT) break;
            adv_step(1'b0, 1'b0, 1'b0, '0);
        end
        chk("reach_last", bus.timer, LastT);
    endtask

    initial begin
        do_reset();

        // First instruction: timer walks CYCLE0..CYCLE4, then PC increments.
        for (int i = 0; i < N; i++) adv_step(1'b0, 1'b0, 1'b0, '0);
        chk("walk_last", bus.timer, 5'b10000);
        adv_step(1'b0, 1'b0, 1'b0, '0);
        chk("pc_first", bus.pc_counter, 16'h0001);
        chk("timer_wrap_c0", bus.timer, 5'b00001);

        // Load, then a plain increment.
        run_to_last();
        adv_step(1'b0, 1'b1, 1'b0, 16'h0003);
        chk("pc_load", bus.pc_counter, 16'h0003);
        run_to_last();
        adv_step(1'b0, 1'b0, 1'b0, '0);
        chk("pc_after_load", bus.pc_counter, 16'h0004);

        // Negative offset, then load beats offset.
        run_to_last();
        adv_step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        chk("pc_offset_neg", bus.pc_counter, 16'h0002);
        run_to_last();
        adv_step(1'b0, 1'b1, 1'b1, 16'h0010);
        chk("pc_load_prio", bus.pc_counter, 16'h0010);

        // Increment carry-out wrap, pulse lasts one clock.
        run_to_last();
        adv_step(1'b0, 1'b1, 1'b0, 16'hFFFF);
        run_to_last();
        adv_step(1'b0, 1'b0, 1'b0, '0);
        chk("pc_inc_wrap", bus.pc_counter, 16'h0000);
        chk("wrap_pulse", bus.pc_wrap, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("wrap_clear", bus.pc_wrap, 1'b0);

        // Signed overflow on offset.
        run_to_last();
        adv_step(1'b0, 1'b1, 1'b0, 16'h7FFF);
        run_to_last();
        adv_step(1'b0, 1'b0, 1'b1, 16'h0001);
        chk("pc_off_ovf", bus.pc_counter, 16'h8000);
        chk("wrap_ovf", bus.pc_wrap, 1'b1);

        // Freeze mid-instruction at CYCLE2.
        adv_step(1'b0, 1'b0, 1'b0, '0);
        adv_step(1'b0, 1'b0, 1'b0, '0);
        chk("at_cycle2", bus.timer, 5'b00100);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("stall_timer", bus.timer, 5'b00100);
        chk("stall_pc", bus.pc_counter, 16'h8000);

        // Early halt dropped before the last cycle has no effect.
        adv_step(1'b1, 1'b0, 1'b0, '0);
        adv_step(1'b0, 1'b0, 1'b0, '0);
        adv_step(1'b0, 1'b0, 1'b0, '0);
        chk("early_halt_ignored", bus.running, 1'b1);

        // Halt at the last cycle.
        run_to_last();
        adv_step(1'b1, 1'b0, 1'b0, '0);
        chk("halt_timer", bus.timer, 0);
        chk("halt_running", bus.running, 1'b0);
        for (int i = 0; i < 6; i++) step(i[0], 1'b0, 1'b0, 1'b0, '0);
        chk("halt_stays", bus.timer, 0);

        // Reset mid-instruction discards the partial instruction.
        do_reset();
        adv_step(1'b0, 1'b0, 1'b0, '0);
        adv_step(1'b0, 1'b0, 1'b0, '0);
        do_reset();

`ifdef CYCLE_STEP_EN
        // Held key gives exactly one advance; five pulses complete an instruction.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("step_hold_once", bus.timer, 5'b00001);
        for (int i = 0; i < 5; i++) adv_step(1'b0, 1'b0, 1'b0, '0);
        chk("step_pc", bus.pc_counter, 16'h0001);
`else
        for (int i = 0; i < 2 * N; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("level_two_instr", bus.pc_counter, 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
